// File: rtl/riscv_pkg.sv
// Shared core definitions: address width plus the return-resolve queue types.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int RRQ_DEPTH = 8;

  typedef struct packed {
    logic            pred_valid;
    logic [XLEN-1:0] pred_target;
  } ret_entry_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } recover_state_t;

endpackage

// File: rtl/rrq_fifo.sv
// Circular buffer with synchronous clear, push, pop and occupancy count.
// The count carries one extra bit so that full and empty are distinct.
module rrq_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = RRQ_DEPTH,
  parameter int W     = $bits(ret_entry_t)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  assign head_data = mem[head];

  // Pointer/count/storage update; clear wins over push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ret_resolve_queue.sv
// Buffers predicted return targets until they resolve, flags mispredicts
// with a registered redirect and blocks fetch for a short recovery window.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   NORMAL  | accepting predictions and resolves
//   RECOVER | post-mispredict window: no enqueue, resolves ignored
module ret_resolve_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH          = RRQ_DEPTH,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enq_valid,
  input  logic                   enq_pred_valid,
  input  logic [XLEN-1:0]        enq_pred_target,
  output logic                   enq_ready,
  input  logic                   res_valid,
  input  logic [XLEN-1:0]        res_target,
  input  logic                   flush,
  output logic                   mispredict,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count,
  output logic                   protocol_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(RECOVER_CYCLES + 1);

  recover_state_t state, state_nxt;
  logic [RW-1:0]  rec_cnt, rec_cnt_nxt;

  ret_entry_t              head_entry;
  logic [$bits(ret_entry_t)-1:0] head_bits;
  ret_entry_t              push_entry;

  logic res_fire;
  logic res_deq;
  logic miss;
  logic enq_fire;
  logic fifo_clear;

  assign head_entry = head_bits;
  assign push_entry = '{pred_valid: enq_pred_valid, pred_target: enq_pred_target};

  // Resolves only count in NORMAL and lose to a same-cycle flush.
  assign res_fire   = (state == NORMAL) && res_valid && !flush;
  assign res_deq    = res_fire && (count != '0);
  assign miss       = res_deq && (!head_entry.pred_valid ||
                                  (head_entry.pred_target != res_target));
  assign enq_fire   = enq_valid && enq_ready;
  assign fifo_clear = flush || miss;

  rrq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(ret_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (fifo_clear),
    .push      (enq_fire && !fifo_clear),
    .push_data (push_entry),
    .pop       (res_deq && !fifo_clear),
    .head_data (head_bits),
    .count     (count)
  );

  // FSM state and recovery down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= NORMAL;
      rec_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rec_cnt <= rec_cnt_nxt;
    end
  end

  // Next state, recovery countdown and enqueue handshake.
  always_comb begin
    state_nxt   = state;
    rec_cnt_nxt = rec_cnt;
    enq_ready   = 1'b0;
    case (state)
      NORMAL: begin
        // A same-cycle resolve frees a slot, so a full queue can still accept.
        enq_ready = (count < CW'(DEPTH)) || res_valid;
        if (miss) begin
          state_nxt   = RECOVER;
          rec_cnt_nxt = RW'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (rec_cnt == '0) state_nxt   = NORMAL;
        else               rec_cnt_nxt = rec_cnt - 1'b1;
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Registered mispredict pulse, redirect target, perf counters and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      protocol_err <= 1'b0;
    end else begin
      mispredict <= miss;
      if (miss) begin
        redirect_pc <= res_target;
        miss_count  <= miss_count + 1'b1;
      end
      if (res_deq && !miss) hit_count <= hit_count + 1'b1;
      if (res_fire && (count == '0)) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ret_resolve_queue.sv
// Bench for ret_resolve_queue: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_ret_resolve_queue;
  import riscv_pkg::*;

  localparam int DEPTH = 8;
  localparam int RC    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enq_valid = 1'b0;
  logic            enq_pred_valid = 1'b0;
  logic [XLEN-1:0] enq_pred_target = '0;
  logic            enq_ready;
  logic            res_valid = 1'b0;
  logic [XLEN-1:0] res_target = '0;
  logic            flush = 1'b0;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   count;
  logic [31:0]     hit_count;
  logic [31:0]     miss_count;
  logic            protocol_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit              v;
    logic [XLEN-1:0] t;
  } mentry_t;

  mentry_t         mq[$];
  int unsigned     m_hits, m_misses;
  bit              m_perr, m_mis;
  logic [XLEN-1:0] m_redir;
  int              m_recov;
  bit              obs_ready, exp_ready;

  ret_resolve_queue #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enq_valid       (enq_valid),
    .enq_pred_valid  (enq_pred_valid),
    .enq_pred_target (enq_pred_target),
    .enq_ready       (enq_ready),
    .res_valid       (res_valid),
    .res_target      (res_target),
    .flush           (flush),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .count           (count),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_hits   = 0;
    m_misses = 0;
    m_perr   = 0;
    m_mis    = 0;
    m_redir  = '0;
    m_recov  = 0;
  endtask

  task automatic idle();
    enq_valid       = 1'b0;
    enq_pred_valid  = 1'b0;
    enq_pred_target = '0;
    res_valid       = 1'b0;
    res_target      = '0;
    flush           = 1'b0;
  endtask

  // One clock: sample handshake, advance the model at the edge, settle.
  task automatic step();
    mentry_t e;
    bit mis;
    #1;
    obs_ready = enq_ready;
    exp_ready = (m_recov == 0) && ((mq.size() < DEPTH) || res_valid);
    @(posedge clk);
    mis = 0;
    if (flush) begin
      mq.delete();
    end else if (m_recov == 0 && res_valid) begin
      if (mq.size() == 0) m_perr = 1;
      else begin
        e = mq.pop_front();
        if (!e.v || e.t != res_target) begin
          mis = 1;
          m_misses++;
          m_redir = res_target;
          mq.delete();
        end else m_hits++;
      end
    end
    if (!flush && !mis && enq_valid && exp_ready)
      mq.push_back('{v: enq_pred_valid, t: enq_pred_target});
    if (m_recov > 0) m_recov--;
    else if (mis) m_recov = RC;
    m_mis = mis;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #3;
    checks++;
    if ({mispredict, protocol_err, enq_ready} !== 3'b001 || count !== '0 ||
        hit_count !== 32'd0 || miss_count !== 32'd0 || redirect_pc !== '0) begin
      failures++;
      $display("FAIL reset_values mis=%b perr=%b rdy=%b cnt=%0d hit=%0d miss=%0d rpc=%h required 0,0,1,0,0,0,0",
               mispredict, protocol_err, enq_ready, count, hit_count, miss_count, redirect_pc);
    end
    do_reset();
    step();
    checks++;
    if (obs_ready !== 1'b1 || count !== '0) begin
      failures++;
      $display("FAIL reset_release rdy=%b cnt=%0d required 1,0", obs_ready, count);
    end
  endtask

  task automatic test_hits();
    bit saw_mis = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1; enq_pred_valid = 1; enq_pred_target = XLEN'((i + 1) * 'h100);
      step();
    end
    idle();
    checks++;
    if (count !== CW'(3)) begin
      failures++;
      $display("FAIL hits_fill cnt=%0d required 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      res_valid = 1; res_target = XLEN'((i + 1) * 'h100);
      step();
      if (mispredict !== 1'b0) saw_mis = 1;
    end
    idle();
    checks++;
    if (saw_mis || hit_count !== 32'd3 || miss_count !== 32'd0 || count !== '0) begin
      failures++;
      $display("FAIL hits_result mis_seen=%b hit=%0d miss=%0d cnt=%0d required 0,3,0,0",
               saw_mis, hit_count, miss_count, count);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    enq_valid = 1; enq_pred_valid = 1; enq_pred_target = 'h400; step();
    enq_pred_target = 'h500; step();
    res_valid = 1; res_target = 'h404; enq_pred_target = 'h600;
    step();
    checks++;
    if (obs_ready !== 1'b1 || mispredict !== 1'b1 || redirect_pc !== 'h404 ||
        count !== '0 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
      failures++;
      $display("FAIL mismatch_pulse rdy=%b mis=%b rpc=%h cnt=%0d miss=%0d hit=%0d required 1,1,404,0,1,0",
               obs_ready, mispredict, redirect_pc, count, miss_count, hit_count);
    end
    res_valid = 0; enq_valid = 1; enq_pred_target = 'h700;
    step();
    checks++;
    if (obs_ready !== 1'b0 || mispredict !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL mismatch_recover1 rdy=%b mis=%b cnt=%0d required 0,0,0", obs_ready, mispredict, count);
    end
    res_valid = 1; res_target = 'h999;
    step();
    checks++;
    if (obs_ready !== 1'b0 || count !== '0 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_recover2 rdy=%b cnt=%0d perr=%b required 0,0,0", obs_ready, count, protocol_err);
    end
    res_valid = 0;
    step();
    checks++;
    if (obs_ready !== 1'b1 || count !== CW'(1)) begin
      failures++;
      $display("FAIL mismatch_after rdy=%b cnt=%0d required 1,1", obs_ready, count);
    end
    idle();
  endtask

  task automatic test_full_wrap();
    bit bad = 0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      enq_valid = 1; enq_pred_valid = 1; enq_pred_target = XLEN'('h1000 + 4 * i);
      step();
    end
    enq_pred_target = 'hdead;
    step();
    checks++;
    if (obs_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      failures++;
      $display("FAIL full_block rdy=%b cnt=%0d required 0,8", obs_ready, count);
    end
    for (int k = 0; k < 20; k++) begin
      enq_valid = 1; enq_pred_valid = 1; enq_pred_target = XLEN'('h2000 + 4 * k);
      res_valid = 1; res_target = mq[0].t;
      step();
      if (obs_ready !== 1'b1 || count !== CW'(DEPTH) || mispredict !== 1'b0) bad = 1;
    end
    idle();
    checks++;
    if (bad || hit_count !== 32'd20 || miss_count !== 32'd0) begin
      failures++;
      $display("FAIL full_wrap bad=%b hit=%0d miss=%0d required 0,20,0", bad, hit_count, miss_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      res_valid = 1; res_target = XLEN'('h2000 + 4 * (12 + i));
      step();
    end
    idle();
    checks++;
    if (count !== '0 || hit_count !== 32'd28 || miss_count !== 32'd0) begin
      failures++;
      $display("FAIL full_drain cnt=%0d hit=%0d miss=%0d required 0,28,0", count, hit_count, miss_count);
    end
  endtask

  task automatic test_invalid_pred();
    do_reset();
    enq_valid = 1; enq_pred_valid = 0; enq_pred_target = '0;
    step();
    idle();
    res_valid = 1; res_target = '0;
    step();
    idle();
    checks++;
    if (mispredict !== 1'b1 || miss_count !== 32'd1 || hit_count !== 32'd0 || redirect_pc !== '0) begin
      failures++;
      $display("FAIL invalid_pred mis=%b miss=%0d hit=%0d rpc=%h required 1,1,0,0",
               mispredict, miss_count, hit_count, redirect_pc);
    end
    step();
    checks++;
    if (mispredict !== 1'b0) begin
      failures++;
      $display("FAIL invalid_pred_pulse mis=%b required 0", mispredict);
    end
  endtask

  task automatic test_flush_empty();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1; enq_pred_valid = 1; enq_pred_target = XLEN'('h700 + 4 * i);
      step();
    end
    flush = 1; res_valid = 1; res_target = 'h700; enq_pred_target = 'h7f0;
    step();
    idle();
    checks++;
    if (count !== '0 || hit_count !== 32'd0 || miss_count !== 32'd0 ||
        mispredict !== 1'b0 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL flush cnt=%0d hit=%0d miss=%0d mis=%b perr=%b required 0,0,0,0,0",
               count, hit_count, miss_count, mispredict, protocol_err);
    end
    res_valid = 1; res_target = 'h123;
    step();
    idle();
    checks++;
    if (protocol_err !== 1'b1 || count !== '0 || hit_count !== 32'd0 ||
        miss_count !== 32'd0 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL empty_resolve perr=%b cnt=%0d hit=%0d miss=%0d mis=%b required 1,0,0,0,0",
               protocol_err, count, hit_count, miss_count, mispredict);
    end
    repeat (3) step();
    enq_valid = 1; enq_pred_valid = 1; enq_pred_target = 'h10;
    step();
    idle();
    checks++;
    if (protocol_err !== 1'b1 || obs_ready !== 1'b1 || count !== CW'(1)) begin
      failures++;
      $display("FAIL perr_sticky perr=%b rdy=%b cnt=%0d required 1,1,1", protocol_err, obs_ready, count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enq_valid = 1; enq_pred_valid = 1; enq_pred_target = 'h800; step();
    enq_pred_target = 'h900; step();
    idle();
    res_valid = 1; res_target = 'h804;
    step();
    idle();
    checks++;
    if (mispredict !== 1'b1) begin
      failures++;
      $display("FAIL async_pre mis=%b required 1", mispredict);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mispredict, protocol_err, enq_ready} !== 3'b001 || count !== '0 ||
        hit_count !== 32'd0 || miss_count !== 32'd0 || redirect_pc !== '0) begin
      failures++;
      $display("FAIL async_reset mis=%b perr=%b rdy=%b cnt=%0d hit=%0d miss=%0d rpc=%h required 0,0,1,0,0,0,0",
               mispredict, protocol_err, enq_ready, count, hit_count, miss_count, redirect_pc);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    enq_valid = 1; enq_pred_valid = 1; enq_pred_target = 'h44;
    step();
    idle();
    checks++;
    if (obs_ready !== 1'b1 || count !== CW'(1)) begin
      failures++;
      $display("FAIL async_release rdy=%b cnt=%0d required 1,1", obs_ready, count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      flush           = ($urandom_range(0, 24) == 0);
      enq_valid       = $urandom_range(0, 1);
      enq_pred_valid  = ($urandom_range(0, 7) != 0);
      enq_pred_target = XLEN'($urandom_range(0, 15) * 4);
      res_valid       = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 5) != 0) res_target = mq[0].t;
      else res_target = XLEN'($urandom_range(0, 15) * 4);
      step();
      checks++;
      if (obs_ready !== exp_ready) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d act=%b exp=%b", c, obs_ready, exp_ready);
      end
      checks++;
      if (count !== CW'(mq.size())) begin
        failures++;
        $display("FAIL rnd_count cyc=%0d act=%0d exp=%0d", c, count, mq.size());
      end
      checks++;
      if (hit_count !== m_hits || miss_count !== m_misses) begin
        failures++;
        $display("FAIL rnd_counters cyc=%0d hit=%0d/%0d miss=%0d/%0d", c, hit_count, m_hits, miss_count, m_misses);
      end
      checks++;
      if (mispredict !== m_mis || (m_mis && redirect_pc !== m_redir)) begin
        failures++;
        $display("FAIL rnd_mispredict cyc=%0d mis=%b exp=%b rpc=%h exp=%h", c, mispredict, m_mis, redirect_pc, m_redir);
      end
      checks++;
      if (protocol_err !== m_perr) begin
        failures++;
        $display("FAIL rnd_perr cyc=%0d act=%b exp=%b", c, protocol_err, m_perr);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hits();
    test_mismatch();
    test_full_wrap();
    test_invalid_pred();
    test_flush_empty();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
